// File: rtl/udma_tx_chan_fetch.sv
// udma_tx_chan_fetch
//   uDMA Tx channel fetch engine. Once started by the control plane it reads
//   L2 over a req/gnt/rvalid port, extracts the addressed byte/half/word,
//   buffers it in a small FIFO and streams it to the peripheral over
//   valid/ready.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   cfg_startaddr_i/size_i/      transfer setup, sampled on cfg_en_i
//     datasize_i/en_i
//   cfg_clr_i                    abort and flush, takes priority over all
//   busy_o, bytes_left_o,        channel status
//     cur_addr_o, done_o
//   l2_req_o, l2_addr_o,         L2 read port (rvalid one cycle after gnt)
//     l2_gnt_i, l2_rvalid_i,
//     l2_rdata_i
//   tx_valid_o, tx_data_o,       peripheral data plane
//     tx_ready_i
module udma_tx_chan_fetch #(
    parameter int L2_AWIDTH  = 19,
    parameter int TRANS_SIZE = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [L2_AWIDTH-1:0]  cfg_startaddr_i,
    input  logic [TRANS_SIZE-1:0] cfg_size_i,
    input  logic [1:0]            cfg_datasize_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_clr_i,
    output logic                  busy_o,
    output logic [TRANS_SIZE-1:0] bytes_left_o,
    output logic [L2_AWIDTH-1:0]  cur_addr_o,
    output logic                  done_o,
    output logic                  l2_req_o,
    output logic [L2_AWIDTH-1:0]  l2_addr_o,
    input  logic                  l2_gnt_i,
    input  logic                  l2_rvalid_i,
    input  logic [31:0]           l2_rdata_i,
    output logic                  tx_valid_o,
    output logic [31:0]           tx_data_o,
    input  logic                  tx_ready_i
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN} state_e;

    state_e                state_q, state_d;
    logic [L2_AWIDTH-1:0]  addr_q, addr_d;
    logic [TRANS_SIZE-1:0] left_q, left_d;
    logic [1:0]            dsize_q, dsize_d;
    logic                  pend_q, pend_d;   // granted beat awaiting rvalid
    logic [1:0]            off_q, off_d;     // byte offset of that beat
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic                  done0_q, done0_d; // size-0 start completion
    logic [31:0]           mem_q [FIFO_DEPTH];

    logic [2:0]  stride;
    logic [CW:0] occ;
    logic        gnt_acc, push, pop;
    logic [31:0] shifted, push_data;

    always_comb begin
        unique case (dsize_q)
            2'b00:   stride = 3'd1;
            2'b01:   stride = 3'd2;
            default: stride = 3'd4;
        endcase
    end

    // Reserve a FIFO slot for every outstanding read so rvalid can never overflow.
    assign occ        = (CW+1)'(cnt_q) + (CW+1)'(pend_q);
    assign l2_req_o   = (state_q == ST_FETCH) && (left_q != '0) && (occ < DEPTH_C);
    assign l2_addr_o  = {addr_q[L2_AWIDTH-1:2], 2'b00};
    assign gnt_acc    = l2_req_o && l2_gnt_i;
    assign push       = pend_q && l2_rvalid_i;
    assign tx_valid_o = (cnt_q != '0);
    assign pop        = tx_valid_o && tx_ready_i;
    assign tx_data_o  = tx_valid_o ? mem_q[rd_q] : 32'h0;

    assign busy_o       = (state_q != ST_IDLE);
    assign bytes_left_o = left_q;
    assign cur_addr_o   = addr_q;
    assign done_o       = done0_q || (state_q == ST_DRAIN && cnt_q == '0);

    assign shifted = l2_rdata_i >> {off_q, 3'b000};
    always_comb begin
        unique case (dsize_q)
            2'b00:   push_data = {24'h0, shifted[7:0]};
            2'b01:   push_data = {16'h0, shifted[15:0]};
            default: push_data = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        dsize_d = dsize_q;
        off_d   = off_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        done0_d = 1'b0;
        pend_d  = gnt_acc || (pend_q && !l2_rvalid_i);

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_en_i) begin
                    if (cfg_size_i != '0) begin
                        state_d = ST_FETCH;
                        addr_d  = cfg_startaddr_i;
                        left_d  = cfg_size_i;
                        dsize_d = cfg_datasize_i;
                    end else begin
                        done0_d = 1'b1;
                    end
                end
            end
            ST_FETCH: if (left_q == '0 && !pend_q) state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_q == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (gnt_acc) begin
            addr_d = addr_q + L2_AWIDTH'(stride);
            // last beat fetches a full datasize even if fewer bytes remain
            left_d = (left_q <= TRANS_SIZE'(stride)) ? '0 : left_q - TRANS_SIZE'(stride);
            off_d  = addr_q[1:0];
        end

        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;

        if (cfg_clr_i) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            left_d  = '0;
            pend_d  = 1'b0;
            cnt_d   = '0;
            wr_d    = '0;
            rd_d    = '0;
            done0_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            left_q  <= '0;
            dsize_q <= '0;
            pend_q  <= 1'b0;
            off_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            done0_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            left_q  <= left_d;
            dsize_q <= dsize_d;
            pend_q  <= pend_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            done0_q <= done0_d;
        end
    end

    // Storage is never observed while empty (tx_data_o is gated), so no reset.
    always_ff @(posedge clk_i) begin
        if (push && !cfg_clr_i) mem_q[wr_q] <= push_data;
    end

endmodule
